// File: rtl/permutation_round_engine.sv
// ---------------------------------------------------------------------------
// permutation_round_engine
//
// Iterative Ascon permutation core. The 320-bit state is held in a register
// and one full round (constant addition, substitution layer, linear diffusion)
// is applied per clock, for 1..12 rounds per job. Valid/ready handshakes on
// both sides let permutations run back to back with no idle cycle.
//
// Ports:
//   i_clk       single clock, rising edge
//   i_rst_n     asynchronous active-low reset
//   i_valid     i_state / i_n_rounds carry a job
//   o_ready     engine can take a job (IDLE, or DONE while i_ready is high)
//   i_state     input state, words x0..x4
//   i_n_rounds  round count, 1..12 (0 and 13..15 run 12 rounds)
//   o_valid     o_state holds a finished result
//   i_ready     consumer takes o_state
//   o_state     state register, valid only while o_valid is high
//   o_busy      rounds are executing
// ---------------------------------------------------------------------------
package permutation_round_engine_pkg;
    // Element 0 is word x0 and sits in the most significant 64 bits.
    typedef logic [0:4][63:0] t_state_array;
endpackage

// ---------------------------------------------------------------------------
// substitution_layer
//
// Applies the Ascon 5-bit S-box to every bit column of the state. Column i
// is {x0[i], x1[i], x2[i], x3[i], x4[i]} with x0 as the MSB.
//
// Ports:
//   i_state  state before substitution
//   o_state  state after substitution
// ---------------------------------------------------------------------------
module substitution_layer
    import permutation_round_engine_pkg::*;
#(
    parameter int NUM_SBOXES = 64
) (
    input  t_state_array i_state,
    output t_state_array o_state
);

    function automatic logic [4:0] sbox(input logic [4:0] x);
        case (x)
            5'h00: sbox = 5'h04;  5'h01: sbox = 5'h0b;  5'h02: sbox = 5'h1f;  5'h03: sbox = 5'h14;
            5'h04: sbox = 5'h1a;  5'h05: sbox = 5'h15;  5'h06: sbox = 5'h09;  5'h07: sbox = 5'h02;
            5'h08: sbox = 5'h1b;  5'h09: sbox = 5'h05;  5'h0a: sbox = 5'h08;  5'h0b: sbox = 5'h12;
            5'h0c: sbox = 5'h1d;  5'h0d: sbox = 5'h03;  5'h0e: sbox = 5'h06;  5'h0f: sbox = 5'h1c;
            5'h10: sbox = 5'h1e;  5'h11: sbox = 5'h13;  5'h12: sbox = 5'h07;  5'h13: sbox = 5'h0e;
            5'h14: sbox = 5'h00;  5'h15: sbox = 5'h0d;  5'h16: sbox = 5'h11;  5'h17: sbox = 5'h18;
            5'h18: sbox = 5'h10;  5'h19: sbox = 5'h0c;  5'h1a: sbox = 5'h01;  5'h1b: sbox = 5'h19;
            5'h1c: sbox = 5'h16;  5'h1d: sbox = 5'h0a;  5'h1e: sbox = 5'h0f;  5'h1f: sbox = 5'h17;
            default: sbox = 5'h00;
        endcase
    endfunction

    logic [4:0] col;

    // NOTE: every variable written in a combinational block gets a default
    // first, so no path through the block can leave it unassigned (no latch).
    always_comb begin
        o_state = '0;
        col     = '0;
        for (int i = 0; i < NUM_SBOXES; i++) begin
            col = sbox({i_state[0][i], i_state[1][i], i_state[2][i],
                        i_state[3][i], i_state[4][i]});
            o_state[0][i] = col[4];
            o_state[1][i] = col[3];
            o_state[2][i] = col[2];
            o_state[3][i] = col[1];
            o_state[4][i] = col[0];
        end
    end

endmodule

module permutation_round_engine
    import permutation_round_engine_pkg::*;
#(
    parameter int NUM_SBOXES = 64
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_valid,
    output logic         o_ready,
    input  t_state_array i_state,
    input  logic [3:0]   i_n_rounds,
    output logic         o_valid,
    input  logic         i_ready,
    output t_state_array o_state,
    output logic         o_busy
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } fsm_t;

    fsm_t         fsm;
    t_state_array state_q;
    logic [3:0]   round_idx;
    logic [3:0]   start_idx;
    logic         accept;
    t_state_array added;
    t_state_array substituted;
    t_state_array diffused;

    // Rounds always end at index 11, so an n-round job starts at 12 - n.
    // Out-of-range counts fall back to the full 12 rounds (start index 0).
    always_comb begin
        if (i_n_rounds == 4'd0 || i_n_rounds > 4'd12) begin
            start_idx = 4'd0;
        end else begin
            start_idx = 4'd12 - i_n_rounds;
        end
    end

    // Combinational path from i_ready: a consumer draining the result lets
    // the next job load on the same edge.
    assign o_ready = (fsm == ST_IDLE) || (fsm == ST_DONE && i_ready);
    assign accept  = i_valid && o_ready;
    assign o_state = state_q;

    // Constant addition into the low byte of x2.
    always_comb begin
        added       = state_q;
        added[2][7:0] = state_q[2][7:0] ^ {4'hF - round_idx, round_idx};
    end

    substitution_layer #(
        .NUM_SBOXES(NUM_SBOXES)
    ) u_substitution_layer (
        .i_state(added),
        .o_state(substituted)
    );

    function automatic logic [63:0] rotr(input logic [63:0] x, input int unsigned k);
        return (x >> k) | (x << (64 - k));
    endfunction

    // Linear diffusion, one rotation pair per word.
    always_comb begin
        diffused[0] = substituted[0] ^ rotr(substituted[0], 19) ^ rotr(substituted[0], 28);
        diffused[1] = substituted[1] ^ rotr(substituted[1], 61) ^ rotr(substituted[1], 39);
        diffused[2] = substituted[2] ^ rotr(substituted[2], 1)  ^ rotr(substituted[2], 6);
        diffused[3] = substituted[3] ^ rotr(substituted[3], 10) ^ rotr(substituted[3], 17);
        diffused[4] = substituted[4] ^ rotr(substituted[4], 7)  ^ rotr(substituted[4], 41);
    end

    // NOTE: clocked state uses non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            // NOTE: the state register is reset because o_state must read 0
            // during reset; it is a flop bank, not a RAM, so this is cheap.
            fsm       <= ST_IDLE;
            state_q   <= '0;
            round_idx <= '0;
            o_valid   <= 1'b0;
            o_busy    <= 1'b0;
        end else begin
            case (fsm)
                ST_IDLE, ST_DONE: begin
                    if (accept) begin
                        fsm       <= ST_RUN;
                        state_q   <= i_state;
                        round_idx <= start_idx;
                        o_valid   <= 1'b0;
                        o_busy    <= 1'b1;
                    end else if (fsm == ST_DONE && i_ready) begin
                        fsm     <= ST_IDLE;
                        o_valid <= 1'b0;
                    end
                end
                ST_RUN: begin
                    state_q   <= diffused;
                    round_idx <= round_idx + 4'd1;
                    if (round_idx == 4'd11) begin
                        fsm     <= ST_DONE;
                        o_valid <= 1'b1;
                        o_busy  <= 1'b0;
                    end
                end
                default: begin
                    fsm     <= ST_IDLE;
                    o_valid <= 1'b0;
                    o_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_permutation_round_engine.sv
// ---------------------------------------------------------------------------
// tb_permutation_round_engine
//
// Self-checking bench for permutation_round_engine. Expected states come from
// a bitsliced Ascon model written straight from the round definitions.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_permutation_round_engine;
    import permutation_round_engine_pkg::*;

    logic         clk;
    logic         rst_n;
    logic         i_valid;
    logic         o_ready;
    t_state_array i_state;
    logic [3:0]   i_n_rounds;
    logic         o_valid;
    logic         i_ready;
    t_state_array o_state;
    logic         o_busy;

    int checks = 0;
    int errors = 0;

    permutation_round_engine #(
        .NUM_SBOXES(64)
    ) dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_valid   (i_valid),
        .o_ready   (o_ready),
        .i_state   (i_state),
        .i_n_rounds(i_n_rounds),
        .o_valid   (o_valid),
        .i_ready   (i_ready),
        .o_state   (o_state),
        .o_busy    (o_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic logic [63:0] rotr(input logic [63:0] x, input int k);
        return (x >> k) | (x << (64 - k));
    endfunction

    function automatic t_state_array model_round(input t_state_array s, input int r);
        logic [63:0] x0, x1, x2, x3, x4, t0, t1, t2, t3, t4;
        logic [7:0]  rc;
        x0 = s[0]; x1 = s[1]; x2 = s[2]; x3 = s[3]; x4 = s[4];
        rc = 8'((15 - r) * 16 + r);
        x2 = x2 ^ {56'd0, rc};
        x0 ^= x4; x4 ^= x3; x2 ^= x1;
        t0 = ~x0 & x1; t1 = ~x1 & x2; t2 = ~x2 & x3; t3 = ~x3 & x4; t4 = ~x4 & x0;
        x0 ^= t1; x1 ^= t2; x2 ^= t3; x3 ^= t4; x4 ^= t0;
        x1 ^= x0; x0 ^= x4; x3 ^= x2; x2 = ~x2;
        x0 = x0 ^ rotr(x0, 19) ^ rotr(x0, 28);
        x1 = x1 ^ rotr(x1, 61) ^ rotr(x1, 39);
        x2 = x2 ^ rotr(x2, 1)  ^ rotr(x2, 6);
        x3 = x3 ^ rotr(x3, 10) ^ rotr(x3, 17);
        x4 = x4 ^ rotr(x4, 7)  ^ rotr(x4, 41);
        return {x0, x1, x2, x3, x4};
    endfunction

    function automatic t_state_array model_perm(input t_state_array s, input int rounds);
        t_state_array v;
        v = s;
        for (int r = 12 - rounds; r < 12; r++) v = model_round(v, r);
        return v;
    endfunction

    function automatic t_state_array rand_state();
        t_state_array v;
        for (int w = 0; w < 5; w++) v[w] = {$urandom, $urandom};
        return v;
    endfunction

    // ---------------- checking helpers ----------------
    task automatic check(input bit ok, input string name,
                         input logic [319:0] act, input logic [319:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called at the falling edge right after the accept edge.
    task automatic wait_result(input int exp_lat, input t_state_array exp, input string name);
        int cycles;
        cycles = 0;
        while (!o_valid && cycles < 40) begin
            @(negedge clk);
            cycles++;
        end
        check(cycles == exp_lat, {name, "_latency"}, 320'(cycles), 320'(exp_lat));
        check(o_state == exp, {name, "_state"}, o_state, exp);
    endtask

    task automatic do_job(input t_state_array s, input logic [3:0] n,
                          input int rounds, input string name);
        @(negedge clk);
        i_valid    = 1'b1;
        i_state    = s;
        i_n_rounds = n;
        @(posedge clk);
        @(negedge clk);
        i_valid = 1'b0;
        wait_result(rounds, model_perm(s, rounds), name);
        @(negedge clk);
        check(!o_valid && o_ready && !o_busy, {name, "_idle"},
              320'({o_valid, o_ready, o_busy}), 320'(3'b010));
    endtask

    typedef struct {
        logic [3:0] n_in;
        int         rounds;
        bit         zero_state;
    } vec_t;

    vec_t vecs[10];
    t_state_array sa, sb, held;
    t_state_array stream_in[50];
    int sent, got, cyc, last_cyc;
    bit acc;

    initial begin
        vecs[0] = '{4'd12, 12, 1'b1};
        vecs[1] = '{4'd12, 12, 1'b0};
        vecs[2] = '{4'd6,  6,  1'b0};
        vecs[3] = '{4'd8,  8,  1'b0};
        vecs[4] = '{4'd0,  12, 1'b0};
        vecs[5] = '{4'd15, 12, 1'b0};
        vecs[6] = '{4'd13, 12, 1'b0};
        vecs[7] = '{4'd1,  1,  1'b0};
        vecs[8] = '{4'd1,  1,  1'b1};
        vecs[9] = '{4'd4,  4,  1'b0};

        rst_n      = 1'b0;
        i_valid    = 1'b0;
        i_ready    = 1'b1;
        i_state    = '0;
        i_n_rounds = 4'd12;
        repeat (2) @(negedge clk);
        check(!o_valid && !o_busy && o_ready, "reset_flags",
              320'({o_valid, o_busy, o_ready}), 320'(3'b001));
        check(o_state == '0, "reset_state", o_state, '0);
        rst_n = 1'b1;

        // Table of single jobs, including out-of-range counts and one round.
        foreach (vecs[i]) begin
            sa = vecs[i].zero_state ? t_state_array'('0) : rand_state();
            do_job(sa, vecs[i].n_in, vecs[i].rounds, $sformatf("vec%0d", i));
        end

        // p12 on random states.
        for (int k = 0; k < 100; k++) do_job(rand_state(), 4'd12, 12, "p12_rand");
        for (int k = 0; k < 5; k++) begin
            do_job(rand_state(), 4'd6, 6, "p6_rand");
            do_job(rand_state(), 4'd8, 8, "p8_rand");
        end

        // Reset asserted mid-RUN aborts the job.
        @(negedge clk);
        i_valid    = 1'b1;
        i_state    = rand_state();
        i_n_rounds = 4'd12;
        @(posedge clk);
        @(negedge clk);
        i_valid = 1'b0;
        repeat (4) @(negedge clk);
        check(o_busy, "pre_reset_busy", 320'(o_busy), 320'(1));
        #2 rst_n = 1'b0;
        #1;
        check(!o_valid && !o_busy && o_ready && o_state == '0, "async_reset",
              {o_state[0:3], 1'b0, o_valid, o_busy, o_ready}, 320'(3'b001));
        repeat (3) begin
            @(negedge clk);
            check(!o_valid && !o_busy && o_ready && o_state == '0, "reset_hold",
                  {o_state[0:3], 1'b0, o_valid, o_busy, o_ready}, 320'(3'b001));
        end
        rst_n = 1'b1;
        @(negedge clk);
        check(o_ready && !o_busy && !o_valid, "post_reset_idle",
              320'({o_valid, o_busy, o_ready}), 320'(3'b001));
        do_job(rand_state(), 4'd6, 6, "post_reset_job");

        // Back-pressure: result held while the consumer stalls.
        sa = rand_state();
        sb = rand_state();
        @(negedge clk);
        i_valid    = 1'b1;
        i_state    = sa;
        i_n_rounds = 4'd8;
        @(posedge clk);
        @(negedge clk);
        i_valid = 1'b0;
        i_ready = 1'b0;
        wait_result(8, model_perm(sa, 8), "bp_first");
        i_valid    = 1'b1;
        i_state    = sb;
        i_n_rounds = 4'd6;
        held       = o_state;
        repeat (20) begin
            @(negedge clk);
            check(o_state == held && !o_ready && o_valid && !o_busy, "bp_hold",
                  {o_state[0:3], 1'b0, o_valid, o_busy, o_ready}, {held[0:3], 64'd4});
        end
        i_ready = 1'b1;
        #1;
        check(o_ready, "bp_ready_comb", 320'(o_ready), 320'(1));
        @(posedge clk);
        @(negedge clk);
        check(o_busy && !o_valid, "bp_reload", 320'({o_valid, o_busy}), 320'(2'b01));
        i_valid = 1'b0;
        wait_result(6, model_perm(sb, 6), "bp_second");
        @(negedge clk);

        // Streaming: 50 back-to-back p6 jobs.
        foreach (stream_in[i]) stream_in[i] = rand_state();
        sent = 0; got = 0; cyc = 0; last_cyc = 0;
        @(negedge clk);
        i_valid    = 1'b1;
        i_state    = stream_in[0];
        i_n_rounds = 4'd6;
        while (got < 50 && cyc < 1000) begin
            acc = o_ready && i_valid;
            @(posedge clk);
            @(negedge clk);
            cyc++;
            if (acc) begin
                sent++;
                if (sent < 50) i_state = stream_in[sent];
                else           i_valid = 1'b0;
            end
            if (o_valid) begin
                check(o_state == model_perm(stream_in[got], 6), "stream_state",
                      o_state, model_perm(stream_in[got], 6));
                if (got > 0)
                    check(cyc - last_cyc == 7, "stream_spacing",
                          320'(cyc - last_cyc), 320'(7));
                else
                    check(cyc == 7, "stream_first", 320'(cyc), 320'(7));
                last_cyc = cyc;
                got++;
            end
        end
        check(got == 50, "stream_count", 320'(got), 320'(50));
        i_valid = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/permutation_round_engine.md
# permutation_round_engine

Iterative Ascon permutation core. It holds the 320-bit state in a register and applies one full round per clock for a programmable 1–12 rounds: constant addition (pC) feeding the `substitution_layer` (pS), followed by linear diffusion (pL). It sits between the mode controller (initialization, absorb, squeeze, finalization) and the state register file. Valid/ready handshakes on both sides allow back-to-back permutations.

## Interface
Parameters:
- `NUM_SBOXES`, 64: forwarded to the `substitution_layer` instance; only 64 is legal.

Ports:
- `i_clk` in 1: single clock; all state updates on rising edge.
- `i_rst_n` in 1: reset, asynchronous, active-low.
- `i_valid` in 1: input state and round count are valid.
- `o_ready` out 1: engine can accept a new permutation.
- `i_state` in `t_state_array`: input state, words x0..x4, 64 bits each.
- `i_n_rounds` in 4: number of rounds, legal 1..12.
- `o_valid` out 1: `o_state` holds a finished permutation result.
- `i_ready` in 1: consumer accepts `o_state`.
- `o_state` out `t_state_array`: permuted state.
- `o_busy` out 1: high while rounds are executing.

## Operation
- FSM states:
  - IDLE: accept when `i_valid && o_ready`. Load `i_state` into the state register and load the round index r = 12 − n. Go to RUN.
  - RUN: each cycle, state ← pL(pS(pC(state, r))) and r ← r + 1. When r == 11 is applied, go to DONE.
  - DONE: hold the result until `i_valid`/`i_ready` events, as below.
- `i_n_rounds` of 0 or 13..15 is treated as 12 rounds.
- pC: x2[7:0] ^= {4'hF − r, r}, with r in 0..11. Constants: 0xF0 for r=0, 0xE1 for r=1, …, 0x4B for r=11.
- pS: instantiates `substitution_layer`. S-box column i is {x0[i], x1[i], x2[i], x3[i], x4[i]}, with x0 as the MSB.
- pL (rotations are right rotations, ⋙):
  - x0 ^= (x0⋙19) ^ (x0⋙28)
  - x1 ^= (x1⋙61) ^ (x1⋙39)
  - x2 ^= (x2⋙1) ^ (x2⋙6)
  - x3 ^= (x3⋙10) ^ (x3⋙17)
  - x4 ^= (x4⋙7) ^ (x4⋙41)
- The round logic is a single combinational round between the state register and itself. No unrolling.
- Handshake signals:
  - `o_ready = (IDLE) || (DONE && i_ready)`. This is a combinational path from `i_ready`.
  - `o_valid = DONE`. `o_busy = RUN`.
- DONE with `i_ready` and no new input: go to IDLE.
- DONE with `i_ready` and `i_valid`: load the new job and go to RUN. There is no idle bubble.
- DONE with `!i_ready`: `o_state` is held stable and `o_ready` stays 0. New input is back-pressured.
- `o_state` is driven directly from the state register. In RUN it shows intermediate values, which are don't-care while `o_valid` = 0.
- `i_valid` changes while the engine is not ready are ignored. There is no input buffering.

## Timing
- Reset (asynchronous assert while `i_rst_n` = 0):
  - FSM goes to IDLE, state register to 0, r to 0.
  - Outputs: `o_valid` = 0, `o_busy` = 0, `o_state` = 0, `o_ready` = 1.
  - Deassertion is synchronized externally.
- Latency, with the accept edge at T:
  - Rounds execute on edges T+1 .. T+n.
  - `o_valid` rises after edge T+n.
  - 1 round: `o_valid` after T+1. 12 rounds: after T+12.
- Throughput: with `i_ready` held high and `i_valid` continuous, one permutation every n+1 cycles.
- Reset asserted mid-RUN or in DONE: the job is aborted immediately and the result is lost. The first cycle after release is IDLE with `o_ready` = 1.
- Output transfer happens on an edge with `o_valid && i_ready`. The simultaneous accept in DONE is the same edge.

## Test plan
- Reset values: hold `i_rst_n` = 0 for 3 cycles mid-RUN. Required: `o_valid` = 0, `o_busy` = 0, `o_ready` = 1 and `o_state` = 0 asynchronously. The next accept works normally.
- p12 on an all-zero state: `i_n_rounds` = 12. Required: `o_valid` exactly 12 cycles after accept, and `o_state` bit-exact to the Python golden model. Repeat for 100 random states.
- p6 and p8 on random states: `i_n_rounds` = 6 uses constants 0x96..0x4B; `i_n_rounds` = 8 starts at 0xB4. Required: latency 6 and 8, golden-model match. Out-of-range `i_n_rounds` = 0 and 15 must equal p12.
- Back-pressure: hold `i_ready` = 0 for 20 cycles after DONE while `i_valid` = 1. Required: `o_state` stable, `o_ready` = 0, no second job starts. On release, the result transfers and the next job loads on the same edge.
- Streaming: 50 back-to-back p6 jobs with `i_ready` = 1. Required: one result every 7 cycles, all in order and matching the golden model.
- Single round: `i_n_rounds` = 1 with a random state. Required: the result equals pL(pS(pC(state, 11))) with constant 0x4B, and `o_valid` arrives one cycle after accept.
